// File: rtl/dds_phase_core.sv
// Phase-accumulator DDS: 27-bit tuning/offset registers, quarter-wave cosine ROM, 4-stage output pipeline.
// Optional SINE output is compiled in when DDS_SINE_OUT_EN is defined.
module dds_phase_core #(
  parameter int ACC_W  = 27,
  parameter int OUT_W  = 10,
  parameter int ROM_AW = 8
) (
  input  logic             CLK_30p72MHz,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             WE,
  input  logic [4:0]       A,
  input  logic [ACC_W-1:0] DATA,
  output logic [OUT_W-1:0] COSINE,
`ifdef DDS_SINE_OUT_EN
  output logic [OUT_W-1:0] SINE,
`endif
  output logic             RDY
);

  localparam int  PH_W      = ROM_AW + 2;
  localparam int  ROM_DEPTH = 1 << ROM_AW;
  localparam int  MAG_W     = OUT_W - 1;
  localparam real HALF_PI   = 1.5707963267948966;

  localparam logic [4:0] ADDR_FTW  = 5'd0;
  localparam logic [4:0] ADDR_POFF = 5'd1;
  localparam logic [4:0] ADDR_CTRL = 5'd2;

  // Half-sample offset keeps every entry strictly inside (0, full scale], so -2^(OUT_W-1) never occurs.
  function automatic logic [ROM_DEPTH*MAG_W-1:0] build_rom();
    logic [ROM_DEPTH*MAG_W-1:0] t;
    real amp;
    real ang;
    t   = '0;
    amp = real'((1 << MAG_W) - 1);
    for (int i = 0; i < ROM_DEPTH; i++) begin
      ang = HALF_PI * (real'(i) + 0.5) / real'(ROM_DEPTH);
      t[i*MAG_W +: MAG_W] = MAG_W'($rtoi(amp * $cos(ang) + 0.5));
    end
    return t;
  endfunction

  localparam logic [ROM_DEPTH*MAG_W-1:0] ROM_TABLE = build_rom();

  // NOTE: the ROM is a constant table, so it has no reset; only the registered read data is reset.
  logic [MAG_W-1:0] rom [ROM_DEPTH];
  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
    assign rom[g] = ROM_TABLE[g*MAG_W +: MAG_W];
  end

  // Odd quadrants walk the quarter wave backwards; quadrants 1 and 2 are negative.
  function automatic logic [ROM_AW-1:0] fold_idx(input logic [1:0] q, input logic [ROM_AW-1:0] idx);
    return q[0] ? ~idx : idx;
  endfunction

  function automatic logic quad_neg(input logic [1:0] q);
    return q[0] ^ q[1];
  endfunction

  // Configuration registers
  logic [ACC_W-1:0] ftw_q, ftw_d;
  logic [ACC_W-1:0] poff_q, poff_d;
  logic             clr;

  // Accumulator and pipeline
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [MAG_W-1:0] rom_q, rom_d;
  logic             neg_q, neg_d;
  logic [OUT_W-1:0] cos_q, cos_d;
  logic [3:0]       valid_q, valid_d;

  logic [1:0]        quad;
  logic [ROM_AW-1:0] idx;

  assign quad = ph_q[PH_W-1 -: 2];
  assign idx  = ph_q[ROM_AW-1:0];

  // NOTE: every always_comb output is given its hold value first, so no path can infer a latch.
  always_comb begin
    ftw_d  = ftw_q;
    poff_d = poff_q;
    clr    = 1'b0;
    if (WE) begin
      case (A)
        ADDR_FTW:  ftw_d  = DATA;
        ADDR_POFF: poff_d = DATA;
        ADDR_CTRL: clr    = DATA[0];
        default:   ;
      endcase
    end
  end

  always_comb begin
    acc_d   = acc_q;
    valid_d = valid_q;
    ph_d    = ph_q;
    rom_d   = rom_q;
    neg_d   = neg_q;
    cos_d   = cos_q;
    if (CE) begin
      acc_d   = acc_q + ftw_q;
      valid_d = {valid_q[2:0], 1'b1};
      ph_d    = PH_W'((acc_q + poff_q) >> (ACC_W - PH_W));
      rom_d   = rom[fold_idx(quad, idx)];
      neg_d   = quad_neg(quad);
      cos_d   = neg_q ? -{1'b0, rom_q} : {1'b0, rom_q};
    end
    // Clear overrides both the stall and the increment; data stages keep flowing.
    if (clr) begin
      acc_d   = '0;
      valid_d = '0;
    end
  end

`ifdef DDS_SINE_OUT_EN
  logic [1:0]       quad_s;
  logic [MAG_W-1:0] rom_s_q, rom_s_d;
  logic             neg_s_q, neg_s_d;
  logic [OUT_W-1:0] sin_q, sin_d;

  // sin(theta) = cos(theta - pi/2): same index, quadrant shifted back by one.
  assign quad_s = quad - 2'd1;

  always_comb begin
    rom_s_d = rom_s_q;
    neg_s_d = neg_s_q;
    sin_d   = sin_q;
    if (CE) begin
      rom_s_d = rom[fold_idx(quad_s, idx)];
      neg_s_d = quad_neg(quad_s);
      sin_d   = neg_s_q ? -{1'b0, rom_s_q} : {1'b0, rom_s_q};
    end
  end

  always_ff @(posedge CLK_30p72MHz) begin
    if (!RST_N) begin
      rom_s_q <= '0;
      neg_s_q <= 1'b0;
      sin_q   <= '0;
    end else begin
      rom_s_q <= rom_s_d;
      neg_s_q <= neg_s_d;
      sin_q   <= sin_d;
    end
  end

  assign SINE = sin_q;
`endif

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge CLK_30p72MHz) begin
    if (!RST_N) begin
      ftw_q   <= '0;
      poff_q  <= '0;
      acc_q   <= '0;
      ph_q    <= '0;
      rom_q   <= '0;
      neg_q   <= 1'b0;
      cos_q   <= '0;
      valid_q <= '0;
    end else begin
      ftw_q   <= ftw_d;
      poff_q  <= poff_d;
      acc_q   <= acc_d;
      ph_q    <= ph_d;
      rom_q   <= rom_d;
      neg_q   <= neg_d;
      cos_q   <= cos_d;
      valid_q <= valid_d;
    end
  end

  assign COSINE = cos_q;
  assign RDY    = valid_q[3];

endmodule

// File: tb/tb_dds_phase_core.sv
// Self-checking bench for dds_phase_core: a vector table with hand-derived outputs plus a
// latency scoreboard fed by an independent phase/cosine model.
module tb_dds_phase_core;

  logic        clk = 1'b0;
  logic        RST_N;
  logic        CE;
  logic        WE;
  logic [4:0]  A;
  logic [26:0] DATA;
  logic [9:0]  COSINE;
  logic        RDY;

  always #5 clk = ~clk;

  dds_phase_core dut (
    .CLK_30p72MHz(clk),
    .RST_N       (RST_N),
    .CE          (CE),
    .WE          (WE),
    .A           (A),
    .DATA        (DATA),
    .COSINE      (COSINE),
    .RDY         (RDY)
  );

  typedef struct {
    logic        rst_n;
    logic        ce;
    logic        we;
    logic [4:0]  a;
    logic [26:0] data;
    logic [9:0]  cos;
    logic        rdy;
  } vec_t;

  vec_t vecs[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [26:0] m_ftw, m_poff, m_acc;
  int          m_valid;
  logic [9:0]  sb[$];
  logic [9:0]  exp_cos;

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, $signed(got), $signed(exp));
    end
  endtask

  function automatic logic [9:0] ref_cos(input logic [9:0] ph);
    int  q, idx, i, mag;
    real ang;
    q   = int'(ph[9:8]);
    idx = int'(ph[7:0]);
    i   = (q == 1 || q == 3) ? 255 - idx : idx;
    ang = 1.5707963267948966 * (real'(i) + 0.5) / 256.0;
    mag = $rtoi(511.0 * $cos(ang) + 0.5);
    return (q == 1 || q == 2) ? 10'(-mag) : 10'(mag);
  endfunction

  task automatic tick(input logic rst_n, input logic ce, input logic we,
                      input logic [4:0] a, input logic [26:0] d);
    logic [26:0] s;
    logic        clr;
    RST_N = rst_n; CE = ce; WE = we; A = a; DATA = d;
    @(posedge clk);
    if (!rst_n) begin
      m_ftw = '0; m_poff = '0; m_acc = '0; m_valid = 0;
      exp_cos = '0;
      sb.delete();
      sb.push_back(10'd0);
      sb.push_back(10'd511);
    end else begin
      if (ce) begin
        s = m_acc + m_poff;
        sb.push_back(ref_cos(s[26:17]));
        exp_cos = sb.pop_front();
      end
      clr = we && (a == 5'd2) && d[0];
      if (clr) m_acc = '0;
      else if (ce) m_acc = m_acc + m_ftw;
      if (clr) m_valid = 0;
      else if (ce && m_valid < 4) m_valid++;
      if (we && a == 5'd0) m_ftw = d;
      if (we && a == 5'd1) m_poff = d;
    end
    #1;
    check("cos_sb", COSINE, exp_cos);
    check("rdy_sb", {9'd0, RDY}, {9'd0, (m_valid == 4)});
  endtask

  function automatic void add_v(input logic rst_n, input logic ce, input logic we, input logic [4:0] a,
                                input logic [26:0] data, input int cos, input logic rdy);
    vec_t v;
    v.rst_n = rst_n; v.ce = ce; v.we = we; v.a = a; v.data = data;
    v.cos = 10'(cos); v.rdy = rdy;
    vecs.push_back(v);
  endfunction

  function automatic void add_p(input logic ce, input int cos, input logic rdy);
    add_v(1'b1, ce, 1'b0, 5'd0, 27'd0, cos, rdy);
  endfunction

  initial begin
    RST_N = 1'b0; CE = 1'b0; WE = 1'b0; A = '0; DATA = '0;
    m_ftw = '0; m_poff = '0; m_acc = '0; m_valid = 0; exp_cos = '0;

    // Reset, then FTW=0 settles to 511 with RDY on the 4th CE edge
    add_v(0, 1, 0, 0, 0, 0, 0);
    add_v(0, 1, 0, 0, 0, 0, 0);
    add_p(1, 0, 0);
    add_p(1, 511, 0);
    add_p(1, 511, 0);
    add_p(1, 511, 1);
    // Quarter-rate tone; the write edge itself still adds the old FTW
    add_v(1, 1, 1, 0, 27'h2000000, 511, 1);
    add_p(1, 511, 1); add_p(1, 511, 1); add_p(1, 511, 1);
    add_p(1, -2, 1);  add_p(1, -511, 1); add_p(1, 2, 1);
    add_p(1, 511, 1); add_p(1, -2, 1);   add_p(1, -511, 1); add_p(1, 2, 1);
    // CE stall for 5 cycles, then resume without a skipped sample
    for (int i = 0; i < 5; i++) add_p(0, 2, 1);
    add_p(1, 511, 1); add_p(1, -2, 1); add_p(1, -511, 1); add_p(1, 2, 1); add_p(1, 511, 1);
    // Clear mid-tone
    add_v(1, 1, 1, 2, 27'd1, -2, 0);
    add_p(1, -511, 0); add_p(1, 2, 0); add_p(1, 511, 0);
    add_p(1, -2, 1);   add_p(1, -511, 1); add_p(1, 2, 1); add_p(1, 511, 1);
    // Write to an unmapped address
    add_v(1, 1, 1, 7, 27'h7FFFFFF, -2, 1);
    add_p(1, -511, 1);
    // FTW=0, clear, then phase offset of half a turn
    add_v(1, 1, 1, 0, 27'd0, 2, 1);
    add_p(1, 511, 1); add_p(1, -2, 1); add_p(1, -511, 1);
    add_v(1, 1, 1, 2, 27'd1, -511, 0);
    add_p(1, -511, 0); add_p(1, -511, 0); add_p(1, 511, 0);
    add_v(1, 1, 1, 1, 27'h4000000, 511, 1);
    add_p(1, 511, 1); add_p(1, 511, 1); add_p(1, -511, 1); add_p(1, -511, 1);
    // Offset back to 0, then FTW = 2^27-1 wraps the accumulator downward
    add_v(1, 1, 1, 1, 27'd0, -511, 1);
    add_v(1, 1, 1, 0, 27'h7FFFFFF, -511, 1);
    add_p(1, -511, 1);
    for (int i = 0; i < 6; i++) add_p(1, 511, 1);
    // Reset mid-sweep with CE low
    add_v(0, 0, 0, 0, 0, 0, 0);
    add_p(0, 0, 0);
    add_p(1, 0, 0); add_p(1, 511, 0); add_p(1, 511, 0); add_p(1, 511, 1);
    // Clear on a CE=0 edge still clears
    add_v(1, 0, 1, 2, 27'd1, 511, 0);
    add_p(1, 511, 0); add_p(1, 511, 0); add_p(1, 511, 0); add_p(1, 511, 1);

    foreach (vecs[k]) begin
      tick(vecs[k].rst_n, vecs[k].ce, vecs[k].we, vecs[k].a, vecs[k].data);
      check($sformatf("cos_tbl[%0d]", k), COSINE, vecs[k].cos);
      check($sformatf("rdy_tbl[%0d]", k), {9'd0, RDY}, {9'd0, vecs[k].rdy});
    end

    // Randomised traffic checked only by the scoreboard
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic        ce, we;
      logic [4:0]  a;
      logic [26:0] d;
      ce = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 3) == 0);
      a  = 5'($urandom_range(0, 7));
      d  = 27'($urandom);
      if (a == 5'd2) d[0] = ($urandom_range(0, 3) == 0);
      tick(1, ce, we, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
